node_sequencer: RTL and testbench
=================================

NODE_SEQUENCER -- requirements
Module: node_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports clk_in and rst_in.
REQ-002 Parameters SHALL be: NUM_NODES, default 4, number of car point masses; POSITION_SIZE, default 8, signed position width; VELOCITY_SIZE, default 8, signed velocity width; ACCELERATION_SIZE, default 3, signed per-node acceleration width; GRAVITY_Y, default -1, signed per-frame velocity-y increment; TIMEOUT_CYCLES, default 255, watchdog limit.
REQ-003 Ports SHALL be:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- begin_in  in  1  frame-update request
- load_in  in  1  write one node's position
- load_idx_in  in  $clog2(NUM_NODES)  node index for load
- load_x_in, load_y_in  in  POSITION_SIZE each  signed load position
- coll_begin_out  out  1  one-cycle start to collision stage
- pos_x_out, pos_y_out  out  POSITION_SIZE each  signed dispatched position
- vel_x_out, vel_y_out  out  VELOCITY_SIZE each  signed dispatched velocity
- coll_result_in  in  1  collision stage result valid
- coll_pos_x_in, coll_pos_y_in  in  POSITION_SIZE each  signed resolved position
- coll_vel_x_in, coll_vel_y_in  in  VELOCITY_SIZE each  signed resolved velocity
- coll_acc_x_in, coll_acc_y_in  in  ACCELERATION_SIZE each  signed contact acceleration
- node_x_out, node_y_out  out  POSITION_SIZE x NUM_NODES  signed stored positions
- frame_acc_x_out, frame_acc_y_out  out  ACCELERATION_SIZE+4 each  signed frame acceleration sum
- busy_out  out  1  high outside IDLE
- done_out  out  1  one-cycle frame-complete pulse

Function
REQ-004 States SHALL be IDLE, DISPATCH, WAIT, WRITEBACK, DONE.
REQ-005 IDLE: begin_in=1 SHALL clear node index and both frame sums and move to DISPATCH next cycle; otherwise remain.
REQ-006 DISPATCH (one cycle): coll_begin_out=1; pos outputs = stored node position; vel_x_out = stored vel_x; vel_y_out = stored vel_y + GRAVITY_Y, saturated to VELOCITY_SIZE; next state WAIT.
REQ-007 pos/vel outputs SHALL hold their dispatched values from DISPATCH until WRITEBACK completes.
REQ-008 WAIT: remain until coll_result_in=1, then capture coll_* inputs and go to WRITEBACK; a coll_result_in high in the DISPATCH cycle SHALL be ignored.
REQ-009 WRITEBACK (one cycle): store captured position and velocity into the current node; add sign-extended acc into frame sums; if index = NUM_NODES-1 go to DONE, else increment index and go to DISPATCH.
REQ-010 DONE: done_out=1 for exactly one cycle, then IDLE; frame_acc outputs hold until next accepted begin_in.
REQ-011 begin_in outside IDLE SHALL be ignored (not queued).
REQ-012 load_in SHALL be accepted only in IDLE: writes node load_idx_in position, zeroes its velocity; load_idx_in >= NUM_NODES ignored; load_in outside IDLE ignored.
REQ-013 load_in and begin_in in the same IDLE cycle: load SHALL take effect and the frame SHALL dispatch the loaded value.
REQ-014 Frame latency with zero-wait collision stage (result one cycle after WAIT entry): 1 + 3*NUM_NODES cycles from begin_in to done_out... plus WAIT cycles as taken.
REQ-015 busy_out SHALL equal (state != IDLE) combinationally.

Reset
REQ-016 rst_in=1 at any clock edge SHALL force IDLE, regardless of state, including mid-frame.
REQ-017 Reset values: all node positions and velocities 0, frame sums 0, coll_begin_out 0, done_out 0, pos/vel outputs 0, index 0, timeout flag 0.
REQ-018 A coll_result_in arriving after a mid-frame reset SHALL be ignored.

Configuration
REQ-019 Macro SEQ_TIMEOUT_EN: when defined, a WAIT cycle counter SHALL, on reaching TIMEOUT_CYCLES, leave the node unchanged, add nothing to frame sums, set a sticky output timeout_out (1 bit, cleared by reset or accepted begin_in), and proceed as in REQ-009; when undefined, no counter or timeout_out port exists and WAIT is unbounded.

Verification
REQ-020 Scenarios:
- Reset, load node0 (10,20), begin_in, stage echoes inputs with acc (1,-1) -> node0 (10,19) stored, vel_y -1, frame_acc (4,-4) for NUM_NODES=4, done_out once.
- Stored vel_y = -128 (VELOCITY_SIZE 8), GRAVITY_Y -1 -> vel_y_out = -128 (saturated).
- begin_in and load_in pulsed during WAIT -> both ignored, frame completes unchanged.
- rst_in asserted in WAIT for node 2, then coll_result_in -> IDLE, all nodes 0, no done_out.
- SEQ_TIMEOUT_EN defined, stage never responds -> after TIMEOUT_CYCLES per node, done_out, timeout_out=1, nodes unchanged.
- Zero-wait stage, NUM_NODES=4 -> done_out exactly 13 cycles after begin_in.

Source files
------------

// File: rtl/node_sequencer.sv
// rtl/node_sequencer.sv - per-node frame sequencer feeding a collision stage (optional watchdog: SEQ_TIMEOUT_EN)
module node_sequencer #(
    parameter int NUM_NODES         = 4,
    parameter int POSITION_SIZE     = 8,
    parameter int VELOCITY_SIZE     = 8,
    parameter int ACCELERATION_SIZE = 3,
    parameter int GRAVITY_Y         = -1,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  begin_in,
    input  logic                                  load_in,
    input  logic [$clog2(NUM_NODES)-1:0]          load_idx_in,
    input  logic signed [POSITION_SIZE-1:0]       load_x_in,
    input  logic signed [POSITION_SIZE-1:0]       load_y_in,
    output logic                                  coll_begin_out,
    output logic signed [POSITION_SIZE-1:0]       pos_x_out,
    output logic signed [POSITION_SIZE-1:0]       pos_y_out,
    output logic signed [VELOCITY_SIZE-1:0]       vel_x_out,
    output logic signed [VELOCITY_SIZE-1:0]       vel_y_out,
    input  logic                                  coll_result_in,
    input  logic signed [POSITION_SIZE-1:0]       coll_pos_x_in,
    input  logic signed [POSITION_SIZE-1:0]       coll_pos_y_in,
    input  logic signed [VELOCITY_SIZE-1:0]       coll_vel_x_in,
    input  logic signed [VELOCITY_SIZE-1:0]       coll_vel_y_in,
    input  logic signed [ACCELERATION_SIZE-1:0]   coll_acc_x_in,
    input  logic signed [ACCELERATION_SIZE-1:0]   coll_acc_y_in,
    output logic [NUM_NODES*POSITION_SIZE-1:0]    node_x_out,
    output logic [NUM_NODES*POSITION_SIZE-1:0]    node_y_out,
    output logic signed [ACCELERATION_SIZE+3:0]   frame_acc_x_out,
    output logic signed [ACCELERATION_SIZE+3:0]   frame_acc_y_out,
    output logic                                  busy_out,
    output logic                                  done_out
`ifdef SEQ_TIMEOUT_EN
    ,
    output logic                                  timeout_out
`endif
);

    localparam int IDX_W = $clog2(NUM_NODES);
    localparam int P     = POSITION_SIZE;
    localparam int V     = VELOCITY_SIZE;
    localparam int A     = ACCELERATION_SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);
    localparam logic signed [V:0] GRAV    = (V + 1)'(GRAVITY_Y);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_WAIT,
        ST_WRITEBACK,
        ST_DONE
    } state_t;

    state_t state;
    logic [IDX_W-1:0] idx;

    logic signed [P-1:0] node_x [NUM_NODES];
    logic signed [P-1:0] node_y [NUM_NODES];
    logic signed [V-1:0] node_vx [NUM_NODES];
    logic signed [V-1:0] node_vy [NUM_NODES];

    logic signed [P-1:0] cap_pos_x, cap_pos_y;
    logic signed [V-1:0] cap_vel_x, cap_vel_y;
    logic signed [A-1:0] cap_acc_x, cap_acc_y;
    logic                cap_valid;

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_flag;
    assign timeout_out = timeout_flag;
`endif

    logic                load_ok;
    logic [IDX_W-1:0]    disp_idx;
    logic signed [P-1:0] src_x, src_y;
    logic signed [V-1:0] src_vx, src_vy;

    // Adds gravity to a velocity, clamping at the signed range limits.
    function automatic logic signed [V-1:0] add_gravity(input logic signed [V-1:0] v);
        logic signed [V:0] s;
        s = {v[V-1], v} + GRAV;
        if (s[V] != s[V-1])
            add_gravity = s[V] ? {1'b1, {(V-1){1'b0}}} : {1'b0, {(V-1){1'b1}}};
        else
            add_gravity = s[V-1:0];
    endfunction

    assign busy_out = (state != ST_IDLE);
    assign load_ok  = load_in && (state == ST_IDLE) && (int'(load_idx_in) < NUM_NODES);

    // Selects the node about to be dispatched; a same-cycle load of node 0 is forwarded.
    always_comb begin
        disp_idx = '0;
        if (state != ST_IDLE && idx != LAST_IDX)
            disp_idx = idx + 1'b1;
        src_x  = node_x[disp_idx];
        src_y  = node_y[disp_idx];
        src_vx = node_vx[disp_idx];
        src_vy = node_vy[disp_idx];
        if (state == ST_IDLE && load_ok && load_idx_in == '0) begin
            src_x  = load_x_in;
            src_y  = load_y_in;
            src_vx = '0;
            src_vy = '0;
        end
    end

    // Flattens node storage onto the observation ports.
    always_comb begin
        node_x_out = '0;
        node_y_out = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            node_x_out[i*P +: P] = node_x[i];
            node_y_out[i*P +: P] = node_y[i];
        end
    end

    // Frame state machine: dispatch each node, await the stage result, write it back.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= ST_IDLE;
            idx             <= '0;
            coll_begin_out  <= 1'b0;
            done_out        <= 1'b0;
            pos_x_out       <= '0;
            pos_y_out       <= '0;
            vel_x_out       <= '0;
            vel_y_out       <= '0;
            frame_acc_x_out <= '0;
            frame_acc_y_out <= '0;
            cap_pos_x       <= '0;
            cap_pos_y       <= '0;
            cap_vel_x       <= '0;
            cap_vel_y       <= '0;
            cap_acc_x       <= '0;
            cap_acc_y       <= '0;
            cap_valid       <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++) begin
                node_x[i]  <= '0;
                node_y[i]  <= '0;
                node_vx[i] <= '0;
                node_vy[i] <= '0;
            end
`ifdef SEQ_TIMEOUT_EN
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_ok) begin
                        node_x[load_idx_in]  <= load_x_in;
                        node_y[load_idx_in]  <= load_y_in;
                        node_vx[load_idx_in] <= '0;
                        node_vy[load_idx_in] <= '0;
                    end
                    if (begin_in) begin
                        idx             <= '0;
                        frame_acc_x_out <= '0;
                        frame_acc_y_out <= '0;
                        coll_begin_out  <= 1'b1;
                        pos_x_out       <= src_x;
                        pos_y_out       <= src_y;
                        vel_x_out       <= src_vx;
                        vel_y_out       <= add_gravity(src_vy);
                        state           <= ST_DISPATCH;
`ifdef SEQ_TIMEOUT_EN
                        timeout_flag    <= 1'b0;
`endif
                    end
                end
                ST_DISPATCH: begin
                    coll_begin_out <= 1'b0;
                    state          <= ST_WAIT;
`ifdef SEQ_TIMEOUT_EN
                    wait_cnt       <= '0;
`endif
                end
                ST_WAIT: begin
                    if (coll_result_in) begin
                        cap_pos_x <= coll_pos_x_in;
                        cap_pos_y <= coll_pos_y_in;
                        cap_vel_x <= coll_vel_x_in;
                        cap_vel_y <= coll_vel_y_in;
                        cap_acc_x <= coll_acc_x_in;
                        cap_acc_y <= coll_acc_y_in;
                        cap_valid <= 1'b1;
                        state     <= ST_WRITEBACK;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cap_valid    <= 1'b0;
                        timeout_flag <= 1'b1;
                        state        <= ST_WRITEBACK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_WRITEBACK: begin
                    if (cap_valid) begin
                        node_x[idx]     <= cap_pos_x;
                        node_y[idx]     <= cap_pos_y;
                        node_vx[idx]    <= cap_vel_x;
                        node_vy[idx]    <= cap_vel_y;
                        frame_acc_x_out <= frame_acc_x_out + {{4{cap_acc_x[A-1]}}, cap_acc_x};
                        frame_acc_y_out <= frame_acc_y_out + {{4{cap_acc_y[A-1]}}, cap_acc_y};
                    end
                    if (idx == LAST_IDX) begin
                        done_out <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        idx            <= idx + 1'b1;
                        coll_begin_out <= 1'b1;
                        pos_x_out      <= src_x;
                        pos_y_out      <= src_y;
                        vel_x_out      <= src_vx;
                        vel_y_out      <= add_gravity(src_vy);
                        state          <= ST_DISPATCH;
                    end
                end
                ST_DONE: begin
                    done_out <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_node_sequencer.sv
// tb/tb_node_sequencer.sv - table-driven self-checking bench for node_sequencer
module tb_node_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        begin_in = 1'b0;
    logic        load_in = 1'b0;
    logic [1:0]  load_idx_in = '0;
    logic signed [7:0] load_x_in = '0, load_y_in = '0;
    logic        coll_begin_out;
    logic signed [7:0] pos_x_out, pos_y_out, vel_x_out, vel_y_out;
    logic        coll_result_in = 1'b0;
    logic signed [7:0] coll_pos_x_in = '0, coll_pos_y_in = '0;
    logic signed [7:0] coll_vel_x_in = '0, coll_vel_y_in = '0;
    logic signed [2:0] coll_acc_x_in = '0, coll_acc_y_in = '0;
    logic [31:0] node_x_out, node_y_out;
    logic signed [6:0] frame_acc_x_out, frame_acc_y_out;
    logic        busy_out, done_out;
`ifdef SEQ_TIMEOUT_EN
    logic        timeout_out;
`endif

    int checks = 0;
    int errors = 0;

    node_sequencer dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .begin_in        (begin_in),
        .load_in         (load_in),
        .load_idx_in     (load_idx_in),
        .load_x_in       (load_x_in),
        .load_y_in       (load_y_in),
        .coll_begin_out  (coll_begin_out),
        .pos_x_out       (pos_x_out),
        .pos_y_out       (pos_y_out),
        .vel_x_out       (vel_x_out),
        .vel_y_out       (vel_y_out),
        .coll_result_in  (coll_result_in),
        .coll_pos_x_in   (coll_pos_x_in),
        .coll_pos_y_in   (coll_pos_y_in),
        .coll_vel_x_in   (coll_vel_x_in),
        .coll_vel_y_in   (coll_vel_y_in),
        .coll_acc_x_in   (coll_acc_x_in),
        .coll_acc_y_in   (coll_acc_y_in),
        .node_x_out      (node_x_out),
        .node_y_out      (node_y_out),
        .frame_acc_x_out (frame_acc_x_out),
        .frame_acc_y_out (frame_acc_y_out),
        .busy_out        (busy_out),
        .done_out        (done_out)
`ifdef SEQ_TIMEOUT_EN
        ,
        .timeout_out     (timeout_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        load_en;
        logic        load_with_begin;
        logic [1:0]  load_idx;
        logic [7:0]  load_x, load_y;
        logic [2:0]  acc_x, acc_y;
        logic [7:0]  wait_n;
        logic        pulse;
        logic        early;
        logic        force_en;
        logic [7:0]  force_vy;
        logic [7:0]  exp_lat;
        logic [7:0]  exp_vy0;
        logic [3:0][7:0] exp_x, exp_y;
        logic [7:0]  exp_ax, exp_ay;
    } vec_t;

    vec_t vecs [5];

    function automatic vec_t mk(input int le, input int lwb, input int li, input int lx, input int ly,
                                input int ax, input int ay, input int wn, input int pl, input int ea,
                                input int fe, input int fv, input int lat, input int vy0,
                                input int x0, input int x1, input int x2, input int x3,
                                input int y0, input int y1, input int y2, input int y3,
                                input int fax, input int fay);
        vec_t v;
        v.load_en = 1'(le);  v.load_with_begin = 1'(lwb); v.load_idx = 2'(li);
        v.load_x = 8'(lx);   v.load_y = 8'(ly);
        v.acc_x = 3'(ax);    v.acc_y = 3'(ay);
        v.wait_n = 8'(wn);   v.pulse = 1'(pl); v.early = 1'(ea);
        v.force_en = 1'(fe); v.force_vy = 8'(fv);
        v.exp_lat = 8'(lat); v.exp_vy0 = 8'(vy0);
        v.exp_x[0] = 8'(x0); v.exp_x[1] = 8'(x1); v.exp_x[2] = 8'(x2); v.exp_x[3] = 8'(x3);
        v.exp_y[0] = 8'(y0); v.exp_y[1] = 8'(y1); v.exp_y[2] = 8'(y2); v.exp_y[3] = 8'(y3);
        v.exp_ax = 8'(fax);  v.exp_ay = 8'(fay);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int lat;
        int g;
        logic signed [7:0] rx, ry, rvx, rvy, vy0;
        lat = 0;
        vy0 = '0;
        if (v.load_en) begin
            load_in = 1'b1; load_idx_in = v.load_idx;
            load_x_in = v.load_x; load_y_in = v.load_y;
            if (!v.load_with_begin) begin
                tick();
                load_in = 1'b0;
            end
        end
        begin_in = 1'b1;
        tick(); lat++;
        begin_in = 1'b0; load_in = 1'b0;
        for (int n = 0; n < 4; n++) begin
            g = 0;
            while (!coll_begin_out && g < 50) begin tick(); lat++; g++; end
            chk($sformatf("v%0d_dispatch_n%0d", k, n), longint'(coll_begin_out), 1);
            if (n == 0) vy0 = vel_y_out;
            rx  = 8'(pos_x_out + vel_x_out);
            ry  = 8'(pos_y_out + vel_y_out);
            rvx = vel_x_out;
            rvy = v.force_en ? v.force_vy : vel_y_out;
            if (v.early && n == 0) begin
                coll_result_in = 1'b1; coll_pos_x_in = 8'sd55; coll_pos_y_in = 8'sd55;
                coll_acc_x_in = 3'sd3; coll_acc_y_in = 3'sd3;
            end
            tick(); lat++;
            coll_result_in = 1'b0;
            for (int w = 0; w < int'(v.wait_n); w++) begin
                if (v.pulse && n == 0 && w == 0) begin
                    begin_in = 1'b1; load_in = 1'b1; load_idx_in = 2'd0;
                    load_x_in = 8'sd99; load_y_in = 8'sd99;
                end
                tick(); lat++;
                begin_in = 1'b0; load_in = 1'b0;
            end
            coll_result_in = 1'b1;
            coll_pos_x_in = rx; coll_pos_y_in = ry;
            coll_vel_x_in = rvx; coll_vel_y_in = rvy;
            coll_acc_x_in = v.acc_x; coll_acc_y_in = v.acc_y;
            tick(); lat++;
            coll_result_in = 1'b0;
            tick(); lat++;
        end
        g = 0;
        while (!done_out && g < 50) begin tick(); lat++; g++; end
        chk($sformatf("v%0d_done", k), longint'(done_out), 1);
        chk($sformatf("v%0d_latency", k), lat, int'(v.exp_lat));
        chk($sformatf("v%0d_vel_y_node0", k), int'(vy0), int'($signed(v.exp_vy0)));
        chk($sformatf("v%0d_acc_x", k), int'(frame_acc_x_out), int'($signed(v.exp_ax)));
        chk($sformatf("v%0d_acc_y", k), int'(frame_acc_y_out), int'($signed(v.exp_ay)));
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("v%0d_node%0d_x", k, n), int'($signed(node_x_out[n*8 +: 8])), int'($signed(v.exp_x[n])));
            chk($sformatf("v%0d_node%0d_y", k, n), int'($signed(node_y_out[n*8 +: 8])), int'($signed(v.exp_y[n])));
        end
        tick();
        chk($sformatf("v%0d_done_one_cycle", k), longint'(done_out), 0);
        chk($sformatf("v%0d_idle_after", k), longint'(busy_out), 0);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int g;
        vecs[0] = mk(1,0,0,10,20,  1,-1, 0, 0,0, 0,0,    13,-1,   10,0,0,0,   19,-1,-1,-1,       4,-4);
        vecs[1] = mk(0,0,0,0,0,   -2, 3, 2, 1,0, 0,0,    21,-2,   10,0,0,0,   17,-3,-3,-3,      -8,12);
        vecs[2] = mk(1,1,2,-5,7,   3, 3, 0, 0,0, 0,0,    13,-3,   10,0,-5,0,  14,-6,6,-6,       12,12);
        vecs[3] = mk(0,0,0,0,0,   -4,-4, 0, 0,1, 1,-128, 13,-4,   10,0,-5,0,  10,-10,4,-10,    -16,-16);
        vecs[4] = mk(0,0,0,0,0,    2,-3, 0, 0,0, 0,0,    13,-128, 10,0,-5,0,  -118,118,-124,118, 8,-12);

        rst_in = 1'b1;
        tick(); tick();
        rst_in = 1'b0;
        chk("reset_busy", longint'(busy_out), 0);
        chk("reset_done", longint'(done_out), 0);
        chk("reset_coll_begin", longint'(coll_begin_out), 0);
        chk("reset_nodes_x", longint'(node_x_out), 0);
        chk("reset_nodes_y", longint'(node_y_out), 0);
        chk("reset_frame_acc", longint'({frame_acc_x_out, frame_acc_y_out}), 0);
        chk("reset_pos_vel", longint'({pos_x_out, pos_y_out, vel_x_out, vel_y_out}), 0);

        for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

        // Reset while node 2 is waiting; a late result must not resume the frame.
        begin_in = 1'b1; tick(); begin_in = 1'b0;
        for (int n = 0; n < 2; n++) begin
            tick();
            coll_result_in = 1'b1; coll_acc_x_in = 3'sd1; coll_acc_y_in = 3'sd1;
            coll_pos_x_in = 8'sd33; coll_pos_y_in = 8'sd33;
            tick();
            coll_result_in = 1'b0;
            tick();
        end
        tick();
        chk("midframe_busy", longint'(busy_out), 1);
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        bad = 0;
        coll_result_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_out || coll_begin_out || busy_out) bad++;
        end
        coll_result_in = 1'b0;
        chk("midreset_no_activity", bad, 0);
        chk("midreset_nodes_x", longint'(node_x_out), 0);
        chk("midreset_nodes_y", longint'(node_y_out), 0);
        chk("midreset_frame_acc", longint'({frame_acc_x_out, frame_acc_y_out}), 0);
        chk("midreset_pos_vel", longint'({pos_x_out, pos_y_out, vel_x_out, vel_y_out}), 0);

`ifdef SEQ_TIMEOUT_EN
        // Silent collision stage: every node times out and is left untouched.
        load_in = 1'b1; load_idx_in = 2'd1; load_x_in = 8'sd7; load_y_in = -8'sd7;
        tick(); load_in = 1'b0;
        begin_in = 1'b1; tick(); begin_in = 1'b0;
        g = 0;
        while (!done_out && g < 1500) begin tick(); g++; end
        chk("timeout_done", longint'(done_out), 1);
        chk("timeout_flag", longint'(timeout_out), 1);
        chk("timeout_node1_x", int'($signed(node_x_out[15:8])), 7);
        chk("timeout_node1_y", int'($signed(node_y_out[15:8])), -7);
        chk("timeout_frame_acc", longint'({frame_acc_x_out, frame_acc_y_out}), 0);
        tick(); tick();
        chk("timeout_sticky", longint'(timeout_out), 1);
        begin_in = 1'b1; tick(); begin_in = 1'b0;
        chk("timeout_cleared_by_begin", longint'(timeout_out), 0);
        rst_in = 1'b1; tick(); rst_in = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
